// File: rtl/fpm_pkg.sv
// ============================================================================
//  Module      : fpm_pkg
//  Description : Shared binary32 types and constants for the sync_fpm multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpm_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam int          BIAS     = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;

    function automatic logic [31:0] signed_inf(input logic sign);
        return {sign, EXP_MAX, 23'h0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpm_core.sv
// ============================================================================
//  Module      : fpm_core
//  Description : Combinational binary32 multiply: unpack, special decode,
//                24x24 multiply, normalize, round, pack.
//                Macro SYNC_FPM_ROUND_NEAREST_EN selects round-to-nearest-even;
//                otherwise the result is truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpm_core
    import fpm_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o
);

`ifdef SYNC_FPM_ROUND_NEAREST_EN
    localparam bit ROUND_NEAREST = 1'b1;
`else
    localparam bit ROUND_NEAREST = 1'b0;
`endif

    localparam logic signed [9:0] BIAS_S10 = 10'(BIAS);

    fp32_t              w_a;
    fp32_t              w_b;
    logic               w_sign;
    logic               w_a_zero, w_b_zero;
    logic               w_a_inf,  w_b_inf;
    logic               w_a_nan,  w_b_nan;
    logic [23:0]        w_man_a,  w_man_b;
    logic [47:0]        w_mprod;
    logic               w_norm_hi;
    logic [22:0]        w_frac_pre;
    logic               w_guard, w_rnd, w_sticky;
    logic               w_round_up;
    logic [23:0]        w_frac_sum;
    logic signed [9:0]  w_exp_pre;
    logic signed [9:0]  w_exp_fin;

    assign w_a    = a_i;
    assign w_b    = b_i;
    assign w_sign = w_a.sign ^ w_b.sign;

    // Exponent 0 covers both zero and denormal encodings; denormals are flushed.
    assign w_a_zero = (w_a.exp == 8'h00);
    assign w_b_zero = (w_b.exp == 8'h00);
    assign w_a_inf  = (w_a.exp == EXP_MAX) && (w_a.frac == 23'h0);
    assign w_b_inf  = (w_b.exp == EXP_MAX) && (w_b.frac == 23'h0);
    assign w_a_nan  = (w_a.exp == EXP_MAX) && (w_a.frac != 23'h0);
    assign w_b_nan  = (w_b.exp == EXP_MAX) && (w_b.frac != 23'h0);

    assign w_man_a = {1'b1, w_a.frac};
    assign w_man_b = {1'b1, w_b.frac};
    assign w_mprod = {24'h0, w_man_a} * {24'h0, w_man_b};

    // Leading one sits at bit 47 or 46; pick the field below it.
    assign w_norm_hi  = w_mprod[47];
    assign w_frac_pre = w_norm_hi ? w_mprod[46:24] : w_mprod[45:23];
    assign w_guard    = w_norm_hi ? w_mprod[23]    : w_mprod[22];
    assign w_rnd      = w_norm_hi ? w_mprod[22]    : w_mprod[21];
    assign w_sticky   = w_norm_hi ? (|w_mprod[21:0]) : (|w_mprod[20:0]);

    assign w_round_up = ROUND_NEAREST & w_guard & (w_rnd | w_sticky | w_frac_pre[0]);

    assign w_exp_pre = $signed({2'b00, w_a.exp}) + $signed({2'b00, w_b.exp})
                     - BIAS_S10 + $signed({9'b0, w_norm_hi});

    // A rounding carry leaves the low 23 bits zero and bumps the exponent.
    assign w_frac_sum = {1'b0, w_frac_pre} + {23'h0, w_round_up};
    assign w_exp_fin  = w_exp_pre + $signed({9'b0, w_frac_sum[23]});

    always_comb begin
        result_o = POS_ZERO;
        if (w_a_nan || w_b_nan) begin
            result_o = QNAN;
        end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            result_o = QNAN;
        end else if (w_a_inf || w_b_inf) begin
            result_o = signed_inf(w_sign);
        end else if (w_a_zero || w_b_zero) begin
            result_o = POS_ZERO;
        end else if (w_exp_fin >= 10'sd255) begin
            result_o = signed_inf(w_sign);
        end else if (w_exp_fin <= 10'sd0) begin
            result_o = POS_ZERO;
        end else begin
            result_o = {w_sign, w_exp_fin[7:0], w_frac_sum[22:0]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/sync_fpm.sv
// ============================================================================
//  Module      : sync_fpm
//  Description : Two-stage pipelined binary32 multiplier (operand registers,
//                combinational core, result register). Rounding mode is
//                selected by macro SYNC_FPM_ROUND_NEAREST_EN (see fpm_core).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fpm
    import fpm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] product
);

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] product_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= POS_ZERO;
            b_q     <= POS_ZERO;
            product <= POS_ZERO;
        end else begin
            a_q     <= A;
            b_q     <= B;
            product <= product_d;
        end
    end

    fpm_core u_core (
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (product_d)
    );

endmodule

`default_nettype wire

// File: tb/tb_sync_fpm.sv
// ============================================================================
//  Module      : tb_sync_fpm
//  Description : Self-checking bench for sync_fpm; reference model uses real
//                arithmetic. Honors SYNC_FPM_ROUND_NEAREST_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fpm;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] product;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

`ifdef SYNC_FPM_ROUND_NEAREST_EN
    localparam logic [31:0] RND_VEC_EXP = 32'h3FC0_0002;
`else
    localparam logic [31:0] RND_VEC_EXP = 32'h3FC0_0001;
`endif

    sync_fpm dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Magnitude of a normal binary32 value as a double (exact widening).
    function automatic real mag(input logic [31:0] x);
        logic [63:0] d;
        d = {1'b0, 11'({3'b000, x[30:23]} + 11'd896), x[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [63:0] d;
        int          e;
        int          m;
        bit          up;
        s      = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        if (a_nan || b_nan) return 32'h7FC0_0000;
        if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
        if (a_inf || b_inf) return {s, 8'hFF, 23'h0};
        if (a_zero || b_zero) return 32'h0;
        // 48-bit significand product is exact in a double.
        d = $realtobits(mag(a) * mag(b));
        e = int'(d[62:52]) - 1023 + 127;
        m = int'(d[51:29]);
`ifdef SYNC_FPM_ROUND_NEAREST_EN
        up = d[28] && ((d[27:0] != 0) || d[29]);
`else
        up = 1'b0;
`endif
        if (up) m = m + 1;
        if (m == (1 << 23)) begin
            m = 0;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return 32'h0;
        return {s, e[7:0], m[22:0]};
    endfunction

    // Drives one operand pair across an edge; returns the expectation now due on product.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                        output logic due, output logic [31:0] due_exp);
        A = a;
        B = b;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        due     = (exp_q.size() >= 2);
        due_exp = 32'h0;
        if (due) due_exp = exp_q.pop_front();
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        logic [7:0]  e;
        logic [22:0] f;
        r = $urandom;
        f = r[22:0];
        case ($urandom_range(0, 9))
            0:       return r;
            1:       e = 8'h00;
            2:       e = 8'hFF;
            3:       e = 8'($urandom_range(200, 254));
            4:       e = 8'($urandom_range(1, 60));
            5: begin
                e = 8'($urandom_range(100, 150));
                f = 23'h7FFFFF ^ 23'($urandom_range(0, 15));
            end
            default: e = 8'($urandom_range(90, 165));
        endcase
        if (e == 8'hFF && $urandom_range(0, 1) == 0) f = 23'h0;
        return {r[31], e, f};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        A   = 32'h4142_0000;
        B   = 32'hC010_0000;
        @(posedge clk);
        #1;
        checks++;
        if (product !== 32'h0) begin
            failures++;
            $display("FAIL reset_value product=%h expected=%h", product, 32'h0);
        end
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
    endtask

    task automatic test_directed();
        logic [31:0] ta[16];
        logic [31:0] tb[16];
        logic [31:0] tp[16];
        logic        due;
        logic [31:0] e;
        ta = '{32'h4142_0000, 32'h4142_0000, 32'hC142_0000, 32'hC0B4_0000,
               32'h3F80_0000, 32'hC0A4_0000, 32'h44BE_0400, 32'hBF90_0000,
               32'h7F80_0000, 32'h7F80_0000, 32'h7F00_0000, 32'h0080_0000,
               32'h7FC0_0001, 32'hFF80_0000, 32'h8000_0000, 32'h0000_0001};
        tb = '{32'hC010_0000, 32'h4142_0000, 32'hC142_0000, 32'h429D_4000,
               32'h429D_4000, 32'h0000_0000, 32'hC4C3_8100, 32'h410C_0000,
               32'h3F80_0000, 32'h0000_0000, 32'h7F00_0000, 32'h0080_0000,
               32'h3F80_0000, 32'h4000_0000, 32'hFF80_0000, 32'h3F80_0000};
        tp = '{32'hC1DA_4000, 32'h4313_0400, 32'h4313_0400, 32'hC3DD_2200,
               32'h429D_4000, 32'h0000_0000, 32'hCA11_1CCC, 32'hC11D_8000,
               32'h7F80_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000,
               32'h7FC0_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h0000_0000};
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) step(ta[i], tb[i], tp[i], due, e);
            else        step(32'h0, 32'h0, 32'h0, due, e);
            if (due) begin
                checks++;
                if (product !== e) begin
                    failures++;
                    $display("FAIL directed[%0d] product=%h expected=%h", i - 1, product, e);
                end
            end
        end
    endtask

    task automatic test_rounding();
        logic        due;
        logic [31:0] e;
        step(32'h3F80_0001, 32'h3FC0_0000, RND_VEC_EXP, due, e);
        for (int i = 0; i < 2; i++) begin
            if (due) begin
                checks++;
                if (product !== e) begin
                    failures++;
                    $display("FAIL rounding[%0d] product=%h expected=%h", i, product, e);
                end
            end
            if (i == 0) step(32'h0, 32'h0, 32'h0, due, e);
        end
    endtask

    task automatic test_reset_midstream();
        logic        due;
        logic [31:0] e;
        step(32'h4142_0000, 32'hC010_0000, 32'hC1DA_4000, due, e);
        if (due) begin
            checks++;
            if (product !== e) begin
                failures++;
                $display("FAIL midstream_pre product=%h expected=%h", product, e);
            end
        end
        step(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, due, e);
        rst = 1'b1;
        A   = 32'h4142_0000;
        B   = 32'h4142_0000;
        @(posedge clk);
        #1;
        checks++;
        if (product !== 32'h0) begin
            failures++;
            $display("FAIL midstream_reset product=%h expected=%h", product, 32'h0);
        end
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        step(32'hC0B4_0000, 32'h429D_4000, 32'hC3DD_2200, due, e);
        checks++;
        if (!due || product !== e) begin
            failures++;
            $display("FAIL midstream_first_post product=%h expected=%h", product, e);
        end
        step(32'h0, 32'h0, 32'h0, due, e);
        checks++;
        if (!due || product !== e) begin
            failures++;
            $display("FAIL midstream_resume product=%h expected=%h", product, e);
        end
    endtask

    task automatic test_back_to_back();
        logic        due;
        logic [31:0] e;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i <= 400; i++) begin
            a = rand_op();
            b = rand_op();
            if (i == 400) begin
                a = 32'h0;
                b = 32'h0;
            end
            step(a, b, ref_mul(a, b), due, e);
            if (due) begin
                checks++;
                if (product !== e) begin
                    failures++;
                    $display("FAIL random[%0d] product=%h expected=%h", i - 1, product, e);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        A   = 32'h0;
        B   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_rounding();
        test_reset_midstream();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
